rs485_word_serializer: RTL

Transmit stage that drains 16-bit words from the RS485 controller's TX FIFO and puts them on the RS485 line. Each word goes out as two 8N1 UART frames, low byte first, LSB first. The block drives the transceiver driver-enable with guard bit-times before and after the frames, then pulses `Tx_complete` so the controller pops the next word. It sits between the controller's FIFO read port and the RS485 PHY pins.

---
 rtl/rs485_word_serializer_pkg.sv | 24 ++
 rtl/rs485_word_serializer_if.sv | 20 ++
 rtl/rs485_word_serializer_baud_tick.sv | 27 ++
 rtl/rs485_word_serializer.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/rs485_word_serializer_pkg.sv
// Shared RS485 definitions: serializer FSM states, UART framing constants and a state decode helper.
package rs485_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        START,
        DATA,
        STOP,
        TRAIL,
        DONE
    } rs485_state_t;

    localparam int   RS485_DATA_BITS      = 8;
    localparam int   RS485_BYTES_PER_WORD = 2;
    localparam logic RS485_START_LVL      = 1'b0;
    localparam logic RS485_STOP_LVL       = 1'b1;

    // The driver is enabled for the whole framed word, guards included.
    function automatic logic rs485_drives_line(input rs485_state_t s);
        return !((s == IDLE) || (s == DONE));
    endfunction

endpackage

// File: rtl/rs485_word_serializer_if.sv
// Word handshake from the TX FIFO plus the RS485 PHY-side line signals.
interface rs485_word_serializer_if;
    logic        word_valid;
    logic [15:0] word_data;
    logic        word_ready;
    logic        Tx;
    logic        Tx_Enable;
    logic        Tx_complete;
    logic        busy;

    modport master (
        output word_valid, word_data,
        input  word_ready, Tx, Tx_Enable, Tx_complete, busy
    );

    modport slave (
        input  word_valid, word_data,
        output word_ready, Tx, Tx_Enable, Tx_complete, busy
    );
endinterface

// File: rtl/rs485_word_serializer_baud_tick.sv
// Bit-time down-counter: reload starts a fresh bit of CLKS_PER_BIT cycles; tick flags its last cycle.
// Latency: tick asserts CLKS_PER_BIT-1 cycles after the reload edge; no backpressure.
module rs485_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic reload,
    output logic tick
);
    localparam int            W          = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [W-1:0]  RELOAD_VAL = W'(CLKS_PER_BIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (reload) begin
            cnt <= RELOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign tick = (cnt == '0);
endmodule

// File: rtl/rs485_word_serializer.sv
// Sends each 16-bit word as two 8N1 frames (low byte first) framed by driver-enable guard bit-times.
// Latency: Tx_Enable rises 1 cycle after accept; word_ready is high only in IDLE/DONE, so the FIFO stalls otherwise.
module rs485_word_serializer
    import rs485_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int GUARD_BITS   = 1
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    rs485_word_serializer_if.slave  bus
);
    localparam logic [3:0]   GUARD_LAST  = 4'(GUARD_BITS > 0 ? GUARD_BITS - 1 : 0);
    localparam logic [2:0]   LAST_BIT    = 3'(RS485_DATA_BITS - 1);
    localparam logic         LAST_BYTE   = 1'(RS485_BYTES_PER_WORD - 1);
    localparam rs485_state_t FIRST_STATE = (GUARD_BITS == 0) ? START : LEAD;

    rs485_state_t state_q, state_d;
    logic [15:0]  shreg_q, shreg_d;
    logic [2:0]   bit_q, bit_d;
    logic         byte_q, byte_d;
    logic [3:0]   guard_q, guard_d;

    logic tx_q, tx_d;
    logic en_q, en_d;
    logic rdy_q, rdy_d;
    logic cmpl_q, cmpl_d;
    logic busy_q, busy_d;

    logic accept;
    logic reload;
    logic tick;

    assign accept = bus.word_valid & rdy_q;

    rs485_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk    (PCLK),
        .rst    (PRESET),
        .reload (reload),
        .tick   (tick)
    );

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q <= IDLE;
            shreg_q <= '0;
            bit_q   <= '0;
            byte_q  <= 1'b0;
            guard_q <= '0;
            tx_q    <= RS485_STOP_LVL;
            en_q    <= 1'b0;
            rdy_q   <= 1'b1;
            cmpl_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            guard_q <= guard_d;
            tx_q    <= tx_d;
            en_q    <= en_d;
            rdy_q   <= rdy_d;
            cmpl_q  <= cmpl_d;
            busy_q  <= busy_d;
        end
    end

    // Every bit boundary reloads the baud counter, so each state lasts exactly one bit-time per step.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        guard_d = guard_q;
        reload  = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    state_d = FIRST_STATE;
                    shreg_d = bus.word_data;
                    bit_d   = '0;
                    byte_d  = 1'b0;
                    guard_d = '0;
                    reload  = 1'b1;
                end
            end
            LEAD: begin
                if (tick) begin
                    reload = 1'b1;
                    if (guard_q == GUARD_LAST) begin
                        state_d = START;
                    end else begin
                        guard_d = guard_q + 4'd1;
                    end
                end
            end
            START: begin
                if (tick) begin
                    reload  = 1'b1;
                    state_d = DATA;
                    bit_d   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    reload  = 1'b1;
                    shreg_d = {1'b0, shreg_q[15:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == LAST_BIT) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    reload = 1'b1;
                    if (byte_q != LAST_BYTE) begin
                        byte_d  = byte_q + 1'b1;
                        state_d = START;
                    end else if (GUARD_BITS == 0) begin
                        state_d = DONE;
                    end else begin
                        guard_d = '0;
                        state_d = TRAIL;
                    end
                end
            end
            TRAIL: begin
                if (tick) begin
                    reload = 1'b1;
                    if (guard_q == GUARD_LAST) begin
                        state_d = DONE;
                    end else begin
                        guard_d = guard_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they flop in step with the state register.
    always_comb begin
        tx_d = RS485_STOP_LVL;
        case (state_d)
            START:   tx_d = RS485_START_LVL;
            DATA:    tx_d = shreg_d[0];
            default: tx_d = RS485_STOP_LVL;
        endcase
        en_d   = rs485_drives_line(state_d);
        busy_d = rs485_drives_line(state_d);
        rdy_d  = (state_d == IDLE) || (state_d == DONE);
        cmpl_d = (state_d == DONE);
    end

    assign bus.Tx          = tx_q;
    assign bus.Tx_Enable   = en_q;
    assign bus.word_ready  = rdy_q;
    assign bus.Tx_complete = cmpl_q;
    assign bus.busy        = busy_q;
endmodule
